// File: rtl/date_sequencer.sv
// Calendar date register (2000..2099) with day tick, validated load,
// and registered month/year rollover and load-error pulses.
module date_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       load,
  input  logic [4:0] load_day,
  input  logic [3:0] load_month,
  input  logic [6:0] load_year,
  output logic [4:0] today,
  output logic [3:0] month,
  output logic [6:0] year,
  output logic [1:0] month_type,
  output logic       month_end,
  output logic       year_end,
  output logic       load_err
);

  // Length class: 00=28, 01=29, 10=30, 11=31. Every multiple of 4 in
  // 2000..2099 is a leap year (2000 included), so year[1:0]==0 suffices.
  function automatic logic [1:0] mtype_of(input logic [3:0] m, input logic [6:0] y);
    case (m)
      4'd2:                       return (y[1:0] == 2'b00) ? 2'b01 : 2'b00;
      4'd4, 4'd6, 4'd9, 4'd11:    return 2'b10;
      default:                    return 2'b11;
    endcase
  endfunction

  // Class encoding is chosen so days-in-month is simply 28 + class.
  function automatic logic [4:0] dim_of(input logic [1:0] mt);
    return 5'd28 + {3'b000, mt};
  endfunction

  logic [4:0] cur_dim, ld_dim;
  logic       cur_valid, ld_ok;
  logic [4:0] nxt_day;
  logic [3:0] nxt_month;
  logic [6:0] nxt_year;
  logic       nxt_me, nxt_ye, nxt_err;

  // Current-date decode and load validation
  always_comb begin
    month_type = mtype_of(month, year);
    cur_dim    = dim_of(month_type);
    ld_dim     = dim_of(mtype_of(load_month, load_year));
    cur_valid  = (month >= 4'd1) && (month <= 4'd12) && (year <= 7'd99) &&
                 (today >= 5'd1) && (today <= cur_dim);
    ld_ok      = (load_month >= 4'd1) && (load_month <= 4'd12) &&
                 (load_year <= 7'd99) &&
                 (load_day >= 5'd1) && (load_day <= ld_dim);
  end

  // Next date and pulses; load wins over tick even when rejected
  always_comb begin
    nxt_day   = today;
    nxt_month = month;
    nxt_year  = year;
    nxt_me    = 1'b0;
    nxt_ye    = 1'b0;
    nxt_err   = 1'b0;
    if (load) begin
      if (ld_ok) begin
        nxt_day   = load_day;
        nxt_month = load_month;
        nxt_year  = load_year;
      end else begin
        nxt_err = 1'b1;
      end
    end else if (tick) begin
      if (!cur_valid) begin
        // Corrupted state recovers to the epoch without signalling a rollover
        nxt_day   = 5'd1;
        nxt_month = 4'd1;
        nxt_year  = 7'd0;
      end else if (today < cur_dim) begin
        nxt_day = today + 5'd1;
      end else begin
        nxt_day = 5'd1;
        nxt_me  = 1'b1;
        if (month == 4'd12) begin
          nxt_month = 4'd1;
          nxt_ye    = 1'b1;
          nxt_year  = (year == 7'd99) ? 7'd0 : year + 7'd1;
        end else begin
          nxt_month = month + 4'd1;
        end
      end
    end
  end

  // Date and pulse registers; reset clears any pending pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      today     <= 5'd1;
      month     <= 4'd1;
      year      <= 7'd0;
      month_end <= 1'b0;
      year_end  <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      today     <= nxt_day;
      month     <= nxt_month;
      year      <= nxt_year;
      month_end <= nxt_me;
      year_end  <= nxt_ye;
      load_err  <= nxt_err;
    end
  end

endmodule

// File: tb/tb_date_sequencer.sv
// Directed vector table plus randomized run against a calendar model.
module tb_date_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, tick, load;
  logic [4:0] load_day;
  logic [3:0] load_month;
  logic [6:0] load_year;
  logic [4:0] today;
  logic [3:0] month;
  logic [6:0] year;
  logic [1:0] month_type;
  logic       month_end, year_end, load_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  date_sequencer dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .load(load),
    .load_day(load_day), .load_month(load_month), .load_year(load_year),
    .today(today), .month(month), .year(year), .month_type(month_type),
    .month_end(month_end), .year_end(year_end), .load_err(load_err)
  );

  // Reference calendar: plain month-length table and leap rule
  int m_day, m_mon, m_year;
  bit m_me, m_ye, m_err;

  function automatic int mdim(input int m, input int y);
    int lens[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m < 1 || m > 12) return 0;
    if (m == 2 && (y % 4) == 0) return 29;
    return lens[m-1];
  endfunction

  task automatic model_step(input bit r, input bit t, input bit l,
                            input int d, input int m, input int y);
    m_me = 0; m_ye = 0; m_err = 0;
    if (!r) begin
      m_day = 1; m_mon = 1; m_year = 0;
    end else if (l) begin
      if (m >= 1 && m <= 12 && y <= 99 && d >= 1 && d <= mdim(m, y)) begin
        m_day = d; m_mon = m; m_year = y;
      end else begin
        m_err = 1;
      end
    end else if (t) begin
      m_day++;
      if (m_day > mdim(m_mon, m_year)) begin
        m_day = 1; m_mon++; m_me = 1;
        if (m_mon > 12) begin
          m_mon = 1; m_ye = 1; m_year = (m_year + 1) % 100;
        end
      end
    end
  endtask

  function automatic logic [20:0] pack(input int d, input int m, input int y,
                                       input int mt, input bit me, input bit ye,
                                       input bit er);
    logic [4:0] pd; logic [3:0] pm; logic [6:0] py; logic [1:0] pt;
    pd = d[4:0]; pm = m[3:0]; py = y[6:0]; pt = mt[1:0];
    return {pd, pm, py, pt, me, ye, er};
  endfunction

  task automatic check(input string name, input logic [20:0] exp);
    logic [20:0] act;
    act = {today, month, year, month_type, month_end, year_end, load_err};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got d=%0d m=%0d y=%0d mt=%0d me=%0b ye=%0b err=%0b, want d=%0d m=%0d y=%0d mt=%0d me=%0b ye=%0b err=%0b",
               name, act[20:16], act[15:12], act[11:5], act[4:3], act[2], act[1], act[0],
               exp[20:16], exp[15:12], exp[11:5], exp[4:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Drive one cycle, advance the model with the same inputs, sample at edge+1
  task automatic apply(input bit r, input bit t, input bit l,
                       input int d, input int m, input int y);
    rst_n = r; tick = t; load = l;
    load_day = d[4:0]; load_month = m[3:0]; load_year = y[6:0];
    @(posedge clk);
    model_step(r, t, l, d, m, y);
    #1;
  endtask

  typedef struct {
    string name;
    bit    r, t, l;
    int    d, m, y;
    int    ed, em, ey, emt;
    bit    eme, eye, eerr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string n, input bit r, input bit t, input bit l,
                              input int d, input int m, input int y,
                              input int ed, input int em, input int ey, input int emt,
                              input bit eme, input bit eye, input bit eerr);
    vec_t v;
    v.name = n; v.r = r; v.t = t; v.l = l; v.d = d; v.m = m; v.y = y;
    v.ed = ed; v.em = em; v.ey = ey; v.emt = emt;
    v.eme = eme; v.eye = eye; v.eerr = eerr;
    return v;
  endfunction

  initial begin
    rst_n = 0; tick = 0; load = 0; load_day = 0; load_month = 0; load_year = 0;

    //                name           rst t  l   d   m   y    ed em ey mt me ye er
    tbl.push_back(mk("rst_tick0",    0, 1, 0,  0,  0,  0,   1, 1, 0, 3, 0, 0, 0));
    tbl.push_back(mk("rst_tick1",    0, 1, 0,  0,  0,  0,   1, 1, 0, 3, 0, 0, 0));
    tbl.push_back(mk("first_tick",   1, 1, 0,  0,  0,  0,   2, 1, 0, 3, 0, 0, 0));
    tbl.push_back(mk("ld_28_02_01",  1, 0, 1, 28,  2,  1,  28, 2, 1, 0, 0, 0, 0));
    tbl.push_back(mk("feb_wrap",     1, 1, 0,  0,  0,  0,   1, 3, 1, 3, 1, 0, 0));
    tbl.push_back(mk("me_clear",     1, 0, 0,  0,  0,  0,   1, 3, 1, 3, 0, 0, 0));
    tbl.push_back(mk("ld_28_02_04",  1, 0, 1, 28,  2,  4,  28, 2, 4, 1, 0, 0, 0));
    tbl.push_back(mk("leap_29",      1, 1, 0,  0,  0,  0,  29, 2, 4, 1, 0, 0, 0));
    tbl.push_back(mk("leap_wrap",    1, 1, 0,  0,  0,  0,   1, 3, 4, 3, 1, 0, 0));
    tbl.push_back(mk("ld_28_02_00",  1, 0, 1, 28,  2,  0,  28, 2, 0, 1, 0, 0, 0));
    tbl.push_back(mk("y2000_29",     1, 1, 0,  0,  0,  0,  29, 2, 0, 1, 0, 0, 0));
    tbl.push_back(mk("ld_31_12_99",  1, 0, 1, 31, 12, 99,  31,12,99, 3, 0, 0, 0));
    tbl.push_back(mk("year_wrap",    1, 1, 0,  0,  0,  0,   1, 1, 0, 3, 1, 1, 0));
    tbl.push_back(mk("yw_clear",     1, 0, 0,  0,  0,  0,   1, 1, 0, 3, 0, 0, 0));
    tbl.push_back(mk("bad_31_04",    1, 0, 1, 31,  4,  5,   1, 1, 0, 3, 0, 0, 1));
    tbl.push_back(mk("bad_29_02_03", 1, 0, 1, 29,  2,  3,   1, 1, 0, 3, 0, 0, 1));
    tbl.push_back(mk("ld_tick_prio", 1, 1, 1, 15,  6, 10,  15, 6,10, 2, 0, 0, 0));
    tbl.push_back(mk("bad_day0_tk",  1, 1, 1,  0,  6, 10,  15, 6,10, 2, 0, 0, 1));
    tbl.push_back(mk("bad_mon13",    1, 0, 1,  1, 13, 10,  15, 6,10, 2, 0, 0, 1));
    tbl.push_back(mk("bad_yr100",    1, 0, 1,  1,  1,100,  15, 6,10, 2, 0, 0, 1));
    tbl.push_back(mk("err_clear",    1, 0, 0,  0,  0,  0,  15, 6,10, 2, 0, 0, 0));
    tbl.push_back(mk("ld_30_04_07",  1, 0, 1, 30,  4,  7,  30, 4, 7, 2, 0, 0, 0));
    tbl.push_back(mk("apr_wrap",     1, 1, 0,  0,  0,  0,   1, 5, 7, 3, 1, 0, 0));
    tbl.push_back(mk("b2b_tick",     1, 1, 0,  0,  0,  0,   2, 5, 7, 3, 0, 0, 0));
    tbl.push_back(mk("ld_30_11_50",  1, 0, 1, 30, 11, 50,  30,11,50, 2, 0, 0, 0));
    tbl.push_back(mk("nov_wrap",     1, 1, 0,  0,  0,  0,   1,12,50, 3, 1, 0, 0));
    tbl.push_back(mk("rst_on_pulse", 0, 1, 0,  0,  0,  0,   1, 1, 0, 3, 0, 0, 0));
    tbl.push_back(mk("post_rst",     1, 0, 0,  0,  0,  0,   1, 1, 0, 3, 0, 0, 0));
    tbl.push_back(mk("ld_30_11_50b", 1, 0, 1, 30, 11, 50,  30,11,50, 2, 0, 0, 0));
    tbl.push_back(mk("rst_vs_wrap",  0, 1, 0,  0,  0,  0,   1, 1, 0, 3, 0, 0, 0));
    tbl.push_back(mk("post_rst_b",   1, 1, 0,  0,  0,  0,   2, 1, 0, 3, 0, 0, 0));

    foreach (tbl[i]) begin
      apply(tbl[i].r, tbl[i].t, tbl[i].l, tbl[i].d, tbl[i].m, tbl[i].y);
      check(tbl[i].name, pack(tbl[i].ed, tbl[i].em, tbl[i].ey, tbl[i].emt,
                              tbl[i].eme, tbl[i].eye, tbl[i].eerr));
    end

    // Randomized run against the model
    for (int n = 0; n < 3000; n++) begin
      bit r, t, l;
      int d, m, y, sel;
      r = ($urandom_range(0, 99) != 0);
      t = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 11) == 0);
      sel = $urandom_range(0, 3);
      if (sel == 0) begin
        d = $urandom_range(0, 31); m = $urandom_range(0, 15); y = $urandom_range(0, 127);
      end else begin
        m = $urandom_range(1, 12); y = $urandom_range(0, 99);
        if (sel == 1) d = mdim(m, y);
        else if (sel == 2) d = mdim(m, y) + 1;
        else d = $urandom_range(1, mdim(m, y));
        if (d > 31) d = 31;
      end
      apply(r, t, l, d, m, y);
      check("random", pack(m_day, m_mon, m_year, mdim(m_mon, m_year) - 28,
                           m_me, m_ye, m_err));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
